bit_enum: RTL

Parametrised, sequential set-bit enumerator. It accepts a WIDTH-bit vector over a valid/ready handshake, then emits the index of every set bit, one per beat, on a second valid/ready handshake, in LSB-first order by default. An all-zero vector is reported explicitly rather than aliased to index 0. It sits between a request-mask producer (interrupt/exception pending bits, register-use masks) and any consumer that services one index at a time.

---
 rtl/bit_enum.sv | 92 +++++++++
 1 files changed

// File: rtl/bit_enum.sv
// Set-bit enumerator: takes a vector, emits each set-bit index one beat at a time.
// Define BIT_ENUM_MSB_FIRST_EN to emit highest index first instead of lowest.
module bit_enum #(
   parameter  int WIDTH = 8,
   localparam int POS_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_last,
   output logic             zero,
   output logic             busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] rem_q;
   logic             zero_q;

   logic [WIDTH-1:0] sel_onehot;
   logic [POS_W-1:0] pos_sel;
   logic [WIDTH-1:0] rem_d;

   // Priority encoder: the last hit in loop order wins, so loop direction sets the order.
   always_comb begin
      pos_sel    = '0;
      sel_onehot = '0;
`ifdef BIT_ENUM_MSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) begin
         if (rem_q[i]) begin
            pos_sel       = POS_W'(i);
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
         end
      end
`else
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rem_q[i]) begin
            pos_sel       = POS_W'(i);
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
         end
      end
`endif
   end

   assign rem_d = rem_q & ~sel_onehot;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         zero_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (in_data == '0) begin
                     zero_q <= 1'b1;
                  end else begin
                     rem_q   <= in_data;
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (out_ready) begin
                  rem_q <= rem_d;
                  if (rem_d == '0) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == SCAN);
   assign busy      = out_valid;
   assign zero      = zero_q;
   assign out_pos   = pos_sel;
   // An empty rem would make the power-of-two test true, so gate it off.
   assign out_last  = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);

endmodule
